// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and baud divider helper for the UART blocks.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int OVS_DEFAULT = 16;
  localparam int DATA_BITS = 8;
  function automatic int div_calc(input int clk, input int baud, input int ovs);
    int d;
    d = clk / (baud * ovs);
    return d < 1 ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator, restartable by clr.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int OVS = OVS_DEFAULT
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  output logic tick
);
  localparam int DIV = div_calc(CLK_FREQ, BAUD, OVS);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 receiver with oversampling, 3-sample majority vote,
// valid/ready holding register, framing-error and overrun pulses.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int OVS = OVS_DEFAULT
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic rx_valid,
  input  logic rx_ready,
  output logic frame_err,
  output logic overrun,
  output logic rx_busy
);
  localparam int OW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);
  rx_state_t state, state_n;
  logic rx_s1, rxs, rxs_prev, s0, s1, tick, done;
  logic start_edge, eval, wrap, maj;
  logic [OW-1:0] os_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  assign start_edge = state == IDLE && rxs_prev && !rxs;
  assign eval = tick && os_cnt == OW'(OVS / 2 + 1);
  assign wrap = tick && os_cnt == OW'(OVS - 1);
  assign maj = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign rx_busy = state != IDLE;
  uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS)) u_tick (
    .PCLK(PCLK), .PRESETn(PRESETn), .clr(start_edge), .tick(tick)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start_edge ? START : IDLE;
      START: state_n = (eval && maj) ? IDLE : wrap ? DATA : START;
      DATA:  state_n = (wrap && bit_cnt == BW'(DATA_BITS - 1)) ? STOP : DATA;
      STOP:  state_n = eval ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      rx_s1 <= 1'b1;
      rxs <= 1'b1;
      rxs_prev <= 1'b1;
      os_cnt <= '0;
      s0 <= 1'b1;
      s1 <= 1'b1;
      bit_cnt <= '0;
      shreg <= '0;
      done <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rxs <= rx_s1;
      rxs_prev <= rxs;
      if (start_edge) os_cnt <= '0;
      else if (tick) os_cnt <= wrap ? '0 : os_cnt + OW'(1);
      if (tick && os_cnt == OW'(OVS / 2 - 1)) s0 <= rxs;
      if (tick && os_cnt == OW'(OVS / 2)) s1 <= rxs;
      if (state == START && wrap) bit_cnt <= '0;
      else if (state == DATA && wrap) bit_cnt <= bit_cnt + BW'(1);
      if (state == DATA && eval) shreg <= {maj, shreg[DATA_BITS-1:1]};
      done <= state == STOP && eval && maj;
      frame_err <= state == STOP && eval && !maj;
      // A completed byte only lands if the holding register is free this cycle
      overrun <= done && rx_valid && !rx_ready;
      if (done && (!rx_valid || rx_ready)) begin
        rx_data <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
endmodule
